// File: rtl/sync_filter_bank_if.sv
// Port bundle for sync_filter_bank: raw inputs in, filtered levels and edge events out.
interface sync_filter_bank_if #(
    parameter int CH = 4
);
    logic [CH-1:0] din;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          change_any;

    modport master (output din, input dout, rise, fall, change_any);
    modport slave  (input din, output dout, rise, fall, change_any);
endinterface

// File: rtl/sync_filter_bank.sv
// Per-channel synchroniser plus stability filter for asynchronous safety inputs.
// Optional rise/fall/change_any event flops are built when SYNC_FILTER_EDGE_EN is defined.
module sync_filter_bank #(
    parameter int            CH        = 4,
    parameter int            STAGES    = 2,
    parameter int            FILTER    = 4,
    parameter logic [CH-1:0] RESET_VAL = '0
) (
    input logic               clk,
    input logic               rstn,
    sync_filter_bank_if.slave bus
);
    localparam int            CW       = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [CH-1:0] sync_q [STAGES];
    logic [CH-1:0] sq;
    logic [CW-1:0] cnt_q  [CH];
    logic [CW-1:0] cnt_d  [CH];
    logic [CH-1:0] dout_q;
    logic [CH-1:0] dout_d;

    // Pure flop chain: s[0] is the only flop sampling the asynchronous pins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
        end else begin
            sync_q[0] <= bus.din;
            for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sq = sync_q[STAGES-1];

    // Any return of sq to dout clears the count, so only FILTER consecutive
    // differing cycles move dout.
    always_comb begin
        dout_d = dout_q;
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = '0;
            if (sq[i] != dout_q[i]) begin
                if (cnt_q[i] == CNT_LAST) dout_d[i] = sq[i];
                else                      cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q <= RESET_VAL;
            for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
        end else begin
            dout_q <= dout_d;
            for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.dout = dout_q;

`ifdef SYNC_FILTER_EDGE_EN
    logic [CH-1:0] rise_q;
    logic [CH-1:0] fall_q;
    logic          change_any_q;

    // Events are computed from the next dout so they line up with the new level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise_q       <= '0;
            fall_q       <= '0;
            change_any_q <= 1'b0;
        end else begin
            rise_q       <= dout_d & ~dout_q;
            fall_q       <= ~dout_d & dout_q;
            change_any_q <= |(rise_q | fall_q);
        end
    end

    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.change_any = change_any_q;
`else
    assign bus.rise       = '0;
    assign bus.fall       = '0;
    assign bus.change_any = 1'b0;
`endif

endmodule

// File: doc/sync_filter_bank.md
# sync_filter_bank

Multi-channel input conditioner for the safety FPGA's asynchronous digital inputs: interlocks, limit switches and external enable lines. Each channel is brought into the `clk` domain by a parametrisable-depth flop chain. A per-channel stability filter then rejects pulses shorter than a programmable number of cycles. Single-cycle rise/fall event pulses are optional. The block sits between the package pins and all safety state machines; no raw pin reaches logic except through it.

## Interface
- `CH`, default 4: number of independent channels, minimum 1.
- `STAGES`, default 2: synchroniser depth in flops, minimum 2.
- `FILTER`, default 4: consecutive cycles a new synchronised value must persist before `dout` follows, minimum 1.
- `RESET_VAL`, default {CH{1'b0}}: per-channel reset value of the sync chain and `dout`.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `din`  in  CH  asynchronous raw inputs.
- `dout`  out  CH  synchronised, filtered level.
- `rise`  out  CH  one-cycle pulse when `dout[i]` goes 0→1.
- `fall`  out  CH  one-cycle pulse when `dout[i]` goes 1→0.
- `change_any`  out  1  registered OR of all `rise|fall` bits.

## Operation
- **Per-channel sync chain.**
  - `s[0] <= din[i]`, `s[k] <= s[k-1]`.
  - `sq = s[STAGES-1]`.
  - Chain flops carry no logic between them.
- **Per-channel counter.**
  - Counter `cnt` has width `$clog2(FILTER+1)` and is unsigned; it never wraps.
  - If `sq == dout[i]`: `cnt <= 0`.
  - If `sq != dout[i]` and `cnt == FILTER-1`: `dout[i] <= sq`, `cnt <= 0`.
  - If `sq != dout[i]` otherwise: `cnt <= cnt+1`.
- **Glitch rejection.** Any return of `sq` to `dout[i]` before the count completes clears `cnt`. A pulse lasting fewer than `FILTER` cycles at `sq` never reaches `dout`.
- **FILTER = 1.** `dout` follows `sq` one cycle later, giving a plain synchroniser plus one register.
- **Events.**
  - `rise[i]` and `fall[i]` are registered and assert in the same cycle `dout[i]` takes its new value, for exactly one cycle.
  - `rise[i]` and `fall[i]` are never both high.
- **Channel independence.** Simultaneous changes on several channels are handled independently. `change_any` is asserted once, in the cycle after the event pulses, for any combination.
- **Reset.**
  - All chain flops and `dout` = `RESET_VAL`; `cnt` = 0; `rise`, `fall` and `change_any` = 0.
  - Reset mid-filter discards the partial count.
  - After release, a `din` differing from `RESET_VAL` propagates normally and produces a genuine `rise` or `fall` event. This is required so downstream logic sees the true initial state.

## Timing
- **Latency.** With `din[i]` changed before edge 0 and held stable:
  - `sq` updates after edge `STAGES-1`.
  - `dout[i]`, `rise` and `fall` update after edge `STAGES-1+FILTER`.
  - `change_any` updates one edge later.
- **Default latency.** For the defaults, `dout` updates at edge 5.
- **Throughput.** Minimum spacing between successive `dout` transitions on one channel is `FILTER` cycles.
- **Asynchronous inputs.** A metastable first-stage sample may resolve either way, adding at most one cycle of uncertainty to the latency above. The bench must accept ±1 cycle only when `din` changes within the setup/hold window.
- **Flop placement.** All outputs are flop outputs; there is no combinational path from `din` to any output. `s[0]` is the only flop driven from a non-`clk` source.

## Configuration
- **Macro `SYNC_FILTER_EDGE_EN`.**
- **Defined.**
  - `rise`, `fall` and `change_any` are generated as described above.
  - Each channel adds one flop for `rise`, one for `fall`, plus a shared `change_any` flop.
- **Undefined.**
  - `rise`, `fall` and `change_any` are tied to constant 0 and no event flops are synthesised.
  - `dout` behaviour and latency are identical in both builds.
  - Ports remain present in both builds.

## Test plan
- **Reset values.** Hold `rstn`=0 with `din`=4'b1010 and `RESET_VAL`=4'b0000 -> `dout`=0 and all events 0 while in reset. Release `rstn` -> `dout[1]` and `dout[3]` rise at edge 5 after release; `rise`=4'b1010 for one cycle; `change_any`=1 one cycle later.
- **Latency and filter.** Set `din[0]` 0→1 held (`STAGES`=2, `FILTER`=4) -> `dout[0]`=1 exactly at edge 5, `rise[0]` is a single cycle, `fall` stays 0. Then apply 3-cycle high pulses on `din[2]` -> `dout[2]` never changes and no events occur. Then apply a 4-cycle pulse -> `dout[2]` pulses high for 4 cycles with one `rise` and one `fall`.
- **Counter clear.** Drive `din[1]` high for 3 cycles, low 1 cycle, high 3 cycles -> `dout[1]` stays 0 throughout.
- **Simultaneous channels.** Toggle all 4 inputs in the same cycle -> all `dout` bits update on the same edge and `change_any` asserts for exactly one cycle.
- **Reset mid-operation.** Assert `rstn` low for 1 cycle while `cnt[0]`=2 -> `dout` returns to `RESET_VAL` asynchronously and `cnt` clears. After release, the full 5-cycle latency is required again.
- **Build variants.** Run the latency scenario with and without `SYNC_FILTER_EDGE_EN` -> `dout` waveform is identical in both builds; without the macro, `rise`, `fall` and `change_any` stay 0 throughout.
